// File: rtl/uart_auth_rx.sv
// rtl/uart_auth_rx.sv - 8N1 UART receiver feeding the rider power-up authorization FSM
module uart_auth_rx #(
  parameter int          CLKS_PER_BIT = 5208,
  parameter logic [7:0]  CMD_GO       = 8'h47,
  parameter logic [7:0]  CMD_STOP     = 8'h53
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_END = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {AUTH_OFF, AUTH_PWR1, AUTH_PWR2} auth_state_t;

  logic          rx_s1, rx_s2, rx_s3;
  logic          rx_fall;
  rx_state_t     rx_state;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift_reg;
  auth_state_t   auth_state, auth_next;

  // Two flops for metastability, the third only for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_rdy    <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      rx_rdy  <= 1'b0;
      frm_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          baud_cnt <= '0;
          if (rx_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (baud_cnt == HALF_END) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) rx_state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_data <= shift_reg;
              rx_rdy  <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // rider_off takes priority over a simultaneous 'G' while in PWR2.
  always_comb begin
    auth_next = auth_state;
    case (auth_state)
      AUTH_OFF:  if (rx_rdy && rx_data == CMD_GO) auth_next = AUTH_PWR1;
      AUTH_PWR1: if (rx_rdy && rx_data == CMD_STOP) auth_next = rider_off ? AUTH_OFF : AUTH_PWR2;
      AUTH_PWR2: begin
        if (rider_off)                         auth_next = AUTH_OFF;
        else if (rx_rdy && rx_data == CMD_GO)  auth_next = AUTH_PWR1;
      end
      default: auth_next = AUTH_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      auth_state <= AUTH_OFF;
      pwr_up     <= 1'b0;
    end else begin
      auth_state <= auth_next;
      pwr_up     <= (auth_next != AUTH_OFF);
    end
  end

endmodule

// File: tb/tb_uart_auth_rx.sv
// tb/tb_uart_auth_rx.sv - directed scoreboard bench for uart_auth_rx
module tb_uart_auth_rx;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] data;
    logic       pwr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       frm_err;
  logic       pwr_up;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   frm_cnt = 0;
  int   rdy_cyc[$];
  exp_t sb[$];
  logic pend_chk = 1'b0;
  logic pend_pwr = 1'b0;

  uart_auth_rx #(.CLKS_PER_BIT(CPB), .CMD_GO(8'h47), .CMD_STOP(8'h53)) dut (
    .clk(clk), .rst(rst), .RX(RX), .rider_off(rider_off),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .frm_err(frm_err), .pwr_up(pwr_up)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every rx_rdy pops one expected byte; pwr_up checked one clock later.
  always @(negedge clk) begin
    if (pend_chk) begin
      pend_chk = 1'b0;
      total++;
      assert (pwr_up === pend_pwr) else begin
        bad++;
        $error("FAIL pwr_after_rdy observed=%0b expected=%0b", pwr_up, pend_pwr);
      end
    end
    if (rx_rdy) begin
      rdy_cyc.push_back(cyc);
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_rdy observed=rx_rdy data=%0h expected=no pulse", rx_data);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (rx_data === e.data) else begin
          bad++;
          $error("FAIL rx_data observed=%0h expected=%0h", rx_data, e.data);
        end
        pend_chk = 1'b1;
        pend_pwr = e.pwr;
      end
    end
    if (frm_err) frm_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, output int start);
    start = cyc;
    RX = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      wait_cyc(CPB);
    end
    RX = stop;
    wait_cyc(CPB);
    RX = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.pwr  = p;
    sb.push_back(e);
  endtask

  initial begin
    int st, st2, n0, f0;
    logic [7:0] g;

    wait_cyc(3);
    rst = 1'b0;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_rdy", 32'(rx_rdy), 32'h0);
    check("reset_frm_err", 32'(frm_err), 32'h0);
    check("reset_pwr_up", 32'(pwr_up), 32'h0);
    wait_cyc(5);

    // 'G' with rider on: OFF -> PWR1
    push(8'h47, 1'b1);
    send_byte(8'h47, 1'b1, st);
    wait_cyc(CPB);
    check("go_rdy_count", 32'(rdy_cyc.size()), 32'd1);
    if (rdy_cyc.size() >= 1) begin
      total++;
      assert (rdy_cyc[0] - st >= 144 && rdy_cyc[0] - st <= 160) else begin
        bad++;
        $error("FAIL go_latency observed=%0d expected=152+-8", rdy_cyc[0] - st);
      end
    end
    check("go_pwr_up", 32'(pwr_up), 32'h1);

    // 'S' with rider on: PWR1 -> PWR2, then rider steps off
    push(8'h53, 1'b1);
    send_byte(8'h53, 1'b1, st);
    wait_cyc(CPB);
    check("stop_rider_on_pwr", 32'(pwr_up), 32'h1);
    rider_off = 1'b1;
    check("rider_off_same_cycle", 32'(pwr_up), 32'h1);
    wait_cyc(1);
    check("rider_off_next_cycle", 32'(pwr_up), 32'h0);
    rider_off = 1'b0;
    wait_cyc(CPB);

    // 'G' then 'S' with rider off: PWR1 -> OFF, then 'S' in OFF is ignored
    push(8'h47, 1'b1);
    send_byte(8'h47, 1'b1, st);
    wait_cyc(CPB);
    rider_off = 1'b1;
    push(8'h53, 1'b0);
    send_byte(8'h53, 1'b1, st);
    wait_cyc(CPB);
    check("stop_rider_off_pwr", 32'(pwr_up), 32'h0);
    push(8'h53, 1'b0);
    send_byte(8'h53, 1'b1, st);
    wait_cyc(CPB);
    check("stop_in_off_pwr", 32'(pwr_up), 32'h0);
    rider_off = 1'b0;

    // Framing error, then a short glitch
    f0 = frm_cnt;
    n0 = rdy_cyc.size();
    send_byte(8'h47, 1'b0, st);
    wait_cyc(2 * CPB);
    check("frm_err_count", 32'(frm_cnt), 32'(f0 + 1));
    check("frm_no_rdy", 32'(rdy_cyc.size()), 32'(n0));
    check("frm_rx_data_held", 32'(rx_data), 32'h53);
    check("frm_pwr_up", 32'(pwr_up), 32'h0);
    RX = 1'b0;
    wait_cyc(4);
    RX = 1'b1;
    wait_cyc(3 * CPB);
    check("glitch_no_frm", 32'(frm_cnt), 32'(f0 + 1));
    check("glitch_no_rdy", 32'(rdy_cyc.size()), 32'(n0));

    // Back-to-back 'G' and 'A' with no idle gap
    n0 = rdy_cyc.size();
    push(8'h47, 1'b1);
    push(8'h41, 1'b1);
    send_byte(8'h47, 1'b1, st);
    send_byte(8'h41, 1'b1, st2);
    wait_cyc(CPB);
    check("b2b_rdy_count", 32'(rdy_cyc.size()), 32'(n0 + 2));
    if (rdy_cyc.size() >= n0 + 2)
      check("b2b_spacing", 32'(rdy_cyc[n0 + 1] - rdy_cyc[n0]), 32'd160);
    check("b2b_pwr_up", 32'(pwr_up), 32'h1);
    check("b2b_rx_data", 32'(rx_data), 32'h41);

    // Reset during data bit 4 of a 'G'
    n0 = rdy_cyc.size();
    f0 = frm_cnt;
    g = 8'h47;
    RX = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      RX = g[i];
      wait_cyc(CPB);
    end
    RX = g[4];
    wait_cyc(CPB / 2);
    rst = 1'b1;
    RX = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("rst_pwr_up", 32'(pwr_up), 32'h0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    wait_cyc(3 * CPB);
    check("rst_no_rdy", 32'(rdy_cyc.size()), 32'(n0));
    check("rst_no_frm", 32'(frm_cnt), 32'(f0));
    push(8'h47, 1'b1);
    send_byte(8'h47, 1'b1, st);
    wait_cyc(CPB);
    check("post_rst_go_pwr", 32'(pwr_up), 32'h1);
    check("post_rst_rx_data", 32'(rx_data), 32'h47);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
